// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the VGA pixel peripheral.
// Free-running x/y beam counters plus registered sync, blank, retrace
// strobes and a sticky frame interrupt with a level clear (cli).
// Optional build macro VGA_SYNC_LINE_IRQ_EN adds irq_line, a second
// interrupt set point at the start of a programmable scanline.
// Every output is a register whose value is derived from the *next*
// counter value, so all strobes line up with x/y in the same cycle.
module vga_sync_gen #(
  parameter int H_VISIBLE  = 1024,
  parameter int H_FRONT    = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BACK     = 160,
  parameter int V_VISIBLE  = 768,
  parameter int V_FRONT    = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 29,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
`ifdef VGA_SYNC_LINE_IRQ_EN
  input  logic [9:0]  irq_line,
`endif
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries pre-sized to the counter widths so every compare is width-exact.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        x_wrap;
  logic        hs_act, vs_act, blank_nxt, retrace_nxt;
  logic        irq_set, irq_vblank, irq_line_hit;

  // Next beam position: x free-runs, y advances only on the x wrap.
  always_comb begin
    x_wrap = (x == H_LAST);
    x_nxt  = x_wrap ? 11'd0 : x + 11'd1;
    y_nxt  = y;
    if (x_wrap) y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
  end

  // Strobes decoded from the next position so they register alongside x/y.
  // vsync depends on y_nxt only, which only moves at the x wrap.
  always_comb begin
    hs_act      = (x_nxt >= H_SYNC_ON) && (x_nxt < H_SYNC_OFF);
    vs_act      = (y_nxt >= V_SYNC_ON) && (y_nxt < V_SYNC_OFF);
    blank_nxt   = (x_nxt >= H_VIS) || (y_nxt >= V_VIS);
    retrace_nxt = (x_nxt == H_VIS) && (y_nxt < V_VIS);
  end

  // Interrupt set points; a programmable line equal to V_VISIBLE simply
  // ORs into the same single set, and lines >= V_TOTAL can never match
  // because y_nxt never reaches them.
  always_comb begin
    irq_vblank   = (x_nxt == 11'd0) && (y_nxt == V_VIS);
`ifdef VGA_SYNC_LINE_IRQ_EN
    irq_line_hit = (x_nxt == 11'd0) && (y_nxt == irq_line);
`else
    irq_line_hit = 1'b0;
`endif
    irq_set      = irq_vblank || irq_line_hit;
  end

  // Counters, strobes and sticky interrupt; set takes priority over cli.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= 11'd0;
      y         <= 10'd0;
      hsync     <= ~H_SYNC_POL;
      vsync     <= ~V_SYNC_POL;
      retrace   <= 1'b0;
      blank     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      x       <= x_nxt;
      y       <= y_nxt;
      hsync   <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync   <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      retrace <= retrace_nxt;
      blank   <= blank_nxt;
      if (irq_set)  interrupt <= 1'b1;
      else if (cli) interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen.
// Instance d uses default (1024x768) timing for reset and one-line checks.
// Instance s uses a shrunken raster (H 16+2+3+4=25, V 8+1+2+2=13,
// frame 325 clocks) so whole-frame, interrupt and async reset behaviour
// can be exercised in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic cli_d, cli_s;
  logic [9:0] irq_d, irq_s;

  logic [10:0] d_x, s_x;
  logic [9:0]  d_y, s_y;
  logic d_hs, d_vs, d_rt, d_bl, d_irq;
  logic s_hs, s_vs, s_rt, s_bl, s_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_d (
    .clk(clk), .rst_n(rst_n), .cli(cli_d),
`ifdef VGA_SYNC_LINE_IRQ_EN
    .irq_line(irq_d),
`endif
    .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
    .retrace(d_rt), .blank(d_bl), .interrupt(d_irq)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .cli(cli_s),
`ifdef VGA_SYNC_LINE_IRQ_EN
    .irq_line(irq_s),
`endif
    .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .retrace(s_rt), .blank(s_bl), .interrupt(s_irq)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance small instance until it shows (tx,ty); budget-bounded.
  task automatic run_to_s(input int tx, input int ty, input string tag);
    int n = 0;
    while (!(s_x == 11'(tx) && s_y == 10'(ty)) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, (n < 400) ? 1 : 0, 1);
  endtask

  int bl_lo, bl_first_hi, hs_lo, hs_first, rt_cnt, rt_x, rt_unblank;
  int vs_lo, vs_first_y, rt_vblank, irq_x, irq_y, irq_rises;
  logic prev_irq;

  initial begin
    rst_n = 1'b0; cli_d = 1'b0; cli_s = 1'b0;
    irq_d = 10'd1023; irq_s = 10'd1023;
    repeat (3) tick();

    // Reset state, default instance
    chk("rst_x", d_x, 0);        chk("rst_y", d_y, 0);
    chk("rst_blank", d_bl, 0);   chk("rst_hsync", d_hs, 1);
    chk("rst_vsync", d_vs, 1);   chk("rst_retrace", d_rt, 0);
    chk("rst_irq", d_irq, 0);

    @(negedge clk) rst_n = 1'b1;
    #1;

    // One full line on the default raster, observed before each edge
    bl_lo = 0; bl_first_hi = -1; hs_lo = 0; hs_first = -1;
    rt_cnt = 0; rt_x = -1; rt_unblank = 0;
    for (int i = 0; i < 1344; i++) begin
      if (!d_bl) bl_lo++;
      else if (bl_first_hi < 0) bl_first_hi = int'(d_x);
      if (!d_hs) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
      if (d_rt) begin
        rt_cnt++;
        rt_x = int'(d_x);
        if (!d_bl) rt_unblank++;
      end
      tick();
    end
    chk("line_blank_lo", bl_lo, 1024);
    chk("line_blank_first", bl_first_hi, 1024);
    chk("line_hsync_lo", hs_lo, 136);
    chk("line_hsync_first", hs_first, 1048);
    chk("line_retrace_cnt", rt_cnt, 1);
    chk("line_retrace_x", rt_x, 1024);
    chk("line_retrace_unblank", rt_unblank, 0);
    chk("line_wrap_x", d_x, 0);
    chk("line_wrap_y", d_y, 1);

    // Small instance is now 1344 mod 325 = 44 clocks in: (19,1), inside
    // hsync, with the vblank interrupt from (0,8) still pending.
    chk("pre_rst_s_x", s_x, 19);
    chk("pre_rst_s_y", s_y, 1);
    chk("pre_rst_s_hsync", s_hs, 0);
    chk("pre_rst_s_irq", s_irq, 1);

    // Asynchronous reset mid-line, checked with no clock edge in between
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_s_x", s_x, 0);       chk("arst_s_y", s_y, 0);
    chk("arst_s_hsync", s_hs, 1);  chk("arst_s_irq", s_irq, 0);
    chk("arst_s_blank", s_bl, 0);  chk("arst_d_y", d_y, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    tick();
    chk("restart_x", s_x, 1);
    chk("restart_y", s_y, 0);

    // Full small frame from (1,0): 324 clocks back to (0,0)
    rt_cnt = 0; rt_vblank = 0; vs_lo = 0; vs_first_y = -1;
    irq_x = -1; irq_y = -1; prev_irq = s_irq;
    for (int i = 0; i < 324; i++) begin
      tick();
      if (s_rt) begin
        rt_cnt++;
        if (s_y >= 10'd8) rt_vblank++;
        if (!s_bl) rt_unblank++;
      end
      if (!s_vs) begin
        vs_lo++;
        if (vs_first_y < 0) vs_first_y = int'(s_y);
      end
      if (s_irq && !prev_irq && irq_x < 0) begin
        irq_x = int'(s_x);
        irq_y = int'(s_y);
      end
      prev_irq = s_irq;
    end
    chk("frame_retrace_cnt", rt_cnt, 8);
    chk("frame_retrace_vblank", rt_vblank, 0);
    chk("frame_retrace_unblank", rt_unblank, 0);
    chk("frame_vsync_cycles", vs_lo, 50);
    chk("frame_vsync_first_y", vs_first_y, 9);
    chk("frame_irq_x", irq_x, 0);
    chk("frame_irq_y", irq_y, 8);
    chk("frame_wrap_x", s_x, 0);
    chk("frame_wrap_y", s_y, 0);
    chk("frame_irq_sticky", s_irq, 1);

    // cli for one clock clears; cli while clear has no effect
    cli_s = 1'b1; tick(); cli_s = 1'b0;
    chk("cli_clear", s_irq, 0);
    tick();
    chk("cli_stays_clear", s_irq, 0);
    cli_s = 1'b1; tick(); cli_s = 1'b0;
    chk("cli_when_clear", s_irq, 0);

    // cli held high across the set point: set wins
    run_to_s(24, 7, "reach_24_7");
    chk("pre_set_irq", s_irq, 0);
    cli_s = 1'b1; tick();
    chk("setwin_pos_y", s_y, 8);
    chk("setwin_irq", s_irq, 1);
    cli_s = 1'b0; tick();
    chk("setwin_irq_after", s_irq, 1);

`ifdef VGA_SYNC_LINE_IRQ_EN
    // Programmable line interrupt at line 3, then vblank again after cli
    cli_s = 1'b1; tick(); cli_s = 1'b0;
    irq_s = 10'd3;
    run_to_s(24, 2, "reach_24_2");
    chk("line_irq_pre", s_irq, 0);
    tick();
    chk("line_irq_set", s_irq, 1);
    cli_s = 1'b1; tick(); cli_s = 1'b0;
    chk("line_irq_clr", s_irq, 0);
    run_to_s(0, 8, "reach_0_8");
    chk("vblank_irq_after_line", s_irq, 1);
    // Out-of-range line: only the vblank set occurs over a full frame
    irq_s = 10'd20;
    cli_s = 1'b1; tick(); cli_s = 1'b0;
    irq_rises = 0; prev_irq = s_irq;
    for (int i = 0; i < 325; i++) begin
      tick();
      if (s_irq && !prev_irq) irq_rises++;
      if (s_irq) begin
        cli_s = 1'b1; tick(); cli_s = 1'b0;
        i++;
      end
      prev_irq = s_irq;
    end
    chk("oor_line_irq_rises", irq_rises, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
